// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the MEM stage
// (CPU port) and a debug/DMA port. Each granted access holds the memory for
// LATENCY cycles (BUSY), then spends one cycle in DONE with the winner's
// ack raised, so back-to-back accesses issue every LATENCY+2 cycles.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i               gate for new grants (in-flight access always completes)
//   cpu_*_i / cpu_*_o     CPU request fields, read data, ack pulse, stall
//   dma_*_i / dma_*_o     DMA request fields, read data, ack pulse
//   mem_*_o / mem_rdata_i memory enable/write/address/data, read data
//   busy_o                high whenever the controller is not IDLE
//
// Build option: define DMEM_ARB_RR_EN for round-robin tie breaking; when it
// is undefined the CPU always wins a tie and no pointer state exists.
module dmem_arbiter #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_ack_o,
  output logic              cpu_stall_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              dma_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state;
  logic [3:0] cnt;       // remaining BUSY cycles after the current one
  logic       sel_dma;   // owner of the access in flight
  logic       pick_dma;  // winner if a grant happens this cycle

`ifdef DMEM_ARB_RR_EN
  logic last_dma;        // last granted port; a tie goes to the other one

  always_comb begin
    pick_dma = dma_req_i & (~cpu_req_i | ~last_dma);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      last_dma <= 1'b1;  // so the CPU wins the first tie
    else if (state == IDLE && start_i && (cpu_req_i || dma_req_i))
      last_dma <= pick_dma;
  end
`else
  always_comb begin
    pick_dma = dma_req_i & ~cpu_req_i;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      sel_dma     <= 1'b0;
      cpu_ack_o   <= 1'b0;
      dma_ack_o   <= 1'b0;
      cpu_rdata_o <= '0;
      dma_rdata_o <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      cpu_ack_o <= 1'b0;
      dma_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && (cpu_req_i || dma_req_i)) begin
            sel_dma     <= pick_dma;
            mem_en_o    <= 1'b1;
            mem_we_o    <= pick_dma ? dma_we_i    : cpu_we_i;
            mem_addr_o  <= pick_dma ? dma_addr_i  : cpu_addr_i;
            mem_wdata_o <= pick_dma ? dma_wdata_i : cpu_wdata_i;
            cnt         <= 4'(LATENCY - 1);
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Last BUSY cycle: read data is valid on this edge.
            if (!mem_we_o) begin
              if (sel_dma) dma_rdata_o <= mem_rdata_i;
              else         cpu_rdata_o <= mem_rdata_i;
            end
            if (sel_dma) dma_ack_o <= 1'b1;
            else         cpu_ack_o <= 1'b1;
            mem_en_o <= 1'b0;
            mem_we_o <= 1'b0;
            state    <= DONE;
          end
        end
        // Ack cycle: requests seen now belong to the finished access.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o      = (state != IDLE);
  assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;

endmodule
